// File: rtl/cosine_similarity_lanes_if.sv
// cosine_similarity_lanes_if
// Bundles the streaming input beat port and the result output port of
// cosine_similarity_lanes.
//   Input beat  : in_valid/in_ready, in_first, in_last, a_data, b_data, lane_mask
//   Result port : out_valid/out_ready, AA_out, BB_out, AB_out, count_out,
//                 overflow, framing_err
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holding valid keeps its payload stable until the transfer.
// The block's ready may depend combinationally on reset and state, never on the
// partner's valid.
// master = producer/consumer side (memory reader + ranking logic), slave = block.
interface cosine_similarity_lanes_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 48
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_first;
  logic                          in_last;
  logic [LANES*DATA_WIDTH-1:0]   a_data;
  logic [LANES*DATA_WIDTH-1:0]   b_data;
  logic [LANES-1:0]              lane_mask;
  logic                          out_valid;
  logic                          out_ready;
  logic [ACC_WIDTH-1:0]          AA_out;
  logic [ACC_WIDTH-1:0]          BB_out;
  logic [ACC_WIDTH-1:0]          AB_out;
  logic [31:0]                   count_out;
  logic                          overflow;
  logic                          framing_err;

  modport master (
    output in_valid, in_first, in_last, a_data, b_data, lane_mask, out_ready,
    input  in_ready, out_valid, AA_out, BB_out, AB_out, count_out, overflow,
           framing_err
  );

  modport slave (
    input  in_valid, in_first, in_last, a_data, b_data, lane_mask, out_ready,
    output in_ready, out_valid, AA_out, BB_out, AB_out, count_out, overflow,
           framing_err
  );
endinterface

// File: rtl/cosine_similarity_lanes.sv
// cosine_similarity_lanes
// Streams LANES signed element pairs of hypervectors A and B per beat and
// accumulates sum(A*A), sum(B*B), sum(A*B) through a 3-stage pipeline:
// stage 1 per-lane products, stage 2 adder tree, stage 3 accumulate.
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset, flushes everything
//   bus         : slave side of cosine_similarity_lanes_if (beats in, sums out)
//   o_dbg_state : current FSM state (0 IDLE, 1 ACCUM, 2 DRAIN, 3 HOLD)
module cosine_similarity_lanes #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 48,
  parameter int SATURATE   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  cosine_similarity_lanes_if.slave      bus,
  output logic [1:0]                    o_dbg_state
);

  localparam int PW = 2 * DATA_WIDTH;             // product width
  localparam int SW = PW + $clog2(LANES);         // lane-sum width
  localparam int CW = $clog2(LANES + 1);          // popcount width

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_t;

  state_t r_state, w_state_nxt;
  logic [1:0] r_drain_cnt;

  logic w_in_ready, w_accept, w_drop, w_restart, w_take, w_hs;

  // Sign-extends both operands one bit past the accumulator so the top two
  // bits of the sum disagree exactly when the signed result overflowed.
  function automatic logic [ACC_WIDTH:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] base,
    input logic signed [SW-1:0]        inc
  );
    logic signed [ACC_WIDTH:0] s;
    logic                      ovf;
    logic [ACC_WIDTH-1:0]      res;
    s   = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(inc);
    ovf = s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
    res = s[ACC_WIDTH-1:0];
    if (ovf && SATURATE != 0)
      res = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return {ovf, res};
  endfunction

  // ---------------- control ----------------
  always_comb begin
    w_in_ready  = (r_state == S_IDLE || r_state == S_ACCUM) && !reset;
    w_accept    = bus.in_valid && w_in_ready;
    // A non-first beat in IDLE has no vector to join, so it is discarded.
    w_drop      = w_accept && (r_state == S_IDLE) && !bus.in_first;
    w_restart   = w_accept && (r_state == S_ACCUM) && bus.in_first;
    w_take      = w_accept && !w_drop;
    w_hs        = (r_state == S_HOLD) && bus.out_ready;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_take) w_state_nxt = bus.in_last ? S_DRAIN : S_ACCUM;
      S_ACCUM: if (w_accept && bus.in_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == 2'd2) w_state_nxt = S_HOLD;
      S_HOLD:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
    end
  end

  // ---------------- stage 1: per-lane products ----------------
  logic signed [DATA_WIDTH-1:0] w_a [LANES];
  logic signed [DATA_WIDTH-1:0] w_b [LANES];
  logic [CW-1:0]                w_pop;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_a[i] = bus.a_data[i*DATA_WIDTH +: DATA_WIDTH];
      w_b[i] = bus.b_data[i*DATA_WIDTH +: DATA_WIDTH];
      w_pop  = w_pop + CW'(bus.lane_mask[i]);
    end
  end

  logic                 r_s1_valid, r_s1_first;
  logic [CW-1:0]        r_s1_cnt;
  logic signed [PW-1:0] r_s1_aa [LANES];
  logic signed [PW-1:0] r_s1_bb [LANES];
  logic signed [PW-1:0] r_s1_ab [LANES];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_cnt   <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_s1_aa[i] <= '0;
        r_s1_bb[i] <= '0;
        r_s1_ab[i] <= '0;
      end
    end else begin
      r_s1_valid <= w_take;
      if (w_take) begin
        r_s1_first <= bus.in_first;
        r_s1_cnt   <= w_pop;
        for (int i = 0; i < LANES; i++) begin
          r_s1_aa[i] <= bus.lane_mask[i] ? PW'(w_a[i]) * PW'(w_a[i]) : '0;
          r_s1_bb[i] <= bus.lane_mask[i] ? PW'(w_b[i]) * PW'(w_b[i]) : '0;
          r_s1_ab[i] <= bus.lane_mask[i] ? PW'(w_a[i]) * PW'(w_b[i]) : '0;
        end
      end
    end
  end

  // ---------------- stage 2: adder tree ----------------
  logic signed [SW-1:0] w_sum_aa, w_sum_bb, w_sum_ab;

  always_comb begin
    w_sum_aa = '0;
    w_sum_bb = '0;
    w_sum_ab = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum_aa = w_sum_aa + SW'(r_s1_aa[i]);
      w_sum_bb = w_sum_bb + SW'(r_s1_bb[i]);
      w_sum_ab = w_sum_ab + SW'(r_s1_ab[i]);
    end
  end

  logic                 r_s2_valid, r_s2_first;
  logic [CW-1:0]        r_s2_cnt;
  logic signed [SW-1:0] r_s2_aa, r_s2_bb, r_s2_ab;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_cnt   <= '0;
      r_s2_aa    <= '0;
      r_s2_bb    <= '0;
      r_s2_ab    <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_first <= r_s1_first;
        r_s2_cnt   <= r_s1_cnt;
        r_s2_aa    <= w_sum_aa;
        r_s2_bb    <= w_sum_bb;
        r_s2_ab    <= w_sum_ab;
      end
    end
  end

  // ---------------- stage 3: accumulate ----------------
  // The first flag travels with its beat, so a restart in ACCUM discards the
  // partial sums exactly when the new first beat reaches the accumulators.
  logic signed [ACC_WIDTH-1:0] r_acc_aa, r_acc_bb, r_acc_ab;
  logic [31:0]                 r_acc_cnt;
  logic                        r_acc_ovf;
  logic signed [ACC_WIDTH-1:0] w_base_aa, w_base_bb, w_base_ab;
  logic [ACC_WIDTH-1:0]        w_new_aa, w_new_bb, w_new_ab;
  logic                        w_ovf_aa, w_ovf_bb, w_ovf_ab;

  always_comb begin
    w_base_aa = r_s2_first ? '0 : r_acc_aa;
    w_base_bb = r_s2_first ? '0 : r_acc_bb;
    w_base_ab = r_s2_first ? '0 : r_acc_ab;
    {w_ovf_aa, w_new_aa} = acc_add(w_base_aa, r_s2_aa);
    {w_ovf_bb, w_new_bb} = acc_add(w_base_bb, r_s2_bb);
    {w_ovf_ab, w_new_ab} = acc_add(w_base_ab, r_s2_ab);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_aa  <= '0;
      r_acc_bb  <= '0;
      r_acc_ab  <= '0;
      r_acc_cnt <= '0;
      r_acc_ovf <= 1'b0;
    end else if (r_s2_valid) begin
      r_acc_aa  <= w_new_aa;
      r_acc_bb  <= w_new_bb;
      r_acc_ab  <= w_new_ab;
      r_acc_cnt <= (r_s2_first ? 32'd0 : r_acc_cnt) + 32'(r_s2_cnt);
      r_acc_ovf <= (r_s2_first ? 1'b0 : r_acc_ovf) | w_ovf_aa | w_ovf_bb | w_ovf_ab;
    end
  end

  // ---------------- output registers ----------------
  // Loaded on the last DRAIN cycle so they change only on entry to HOLD.
  logic [ACC_WIDTH-1:0] r_out_aa, r_out_bb, r_out_ab;
  logic [31:0]          r_out_cnt;
  logic                 r_out_ovf, r_ferr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_aa  <= '0;
      r_out_bb  <= '0;
      r_out_ab  <= '0;
      r_out_cnt <= '0;
      r_out_ovf <= 1'b0;
    end else if (r_state == S_DRAIN && r_drain_cnt == 2'd2) begin
      r_out_aa  <= r_acc_aa;
      r_out_bb  <= r_acc_bb;
      r_out_ab  <= r_acc_ab;
      r_out_cnt <= r_acc_cnt;
      r_out_ovf <= r_acc_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                    r_ferr <= 1'b0;
    else if (w_drop || w_restart) r_ferr <= 1'b1;
    else if (w_hs)                r_ferr <= 1'b0;
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state == S_HOLD);
  assign bus.AA_out      = r_out_aa;
  assign bus.BB_out      = r_out_bb;
  assign bus.AB_out      = r_out_ab;
  assign bus.count_out   = r_out_cnt;
  assign bus.overflow    = r_out_ovf;
  assign bus.framing_err = r_ferr;
  assign o_dbg_state     = r_state;

endmodule

// File: doc/cosine_similarity_lanes.md
# cosine_similarity_lanes

Parametrised successor to the single-lane cosine-similarity accumulator. It streams LANES element pairs of hypervectors A and B per beat and reduces them through a 3-stage signed fixed-point pipeline into the three dot products sum(A·A), sum(B·B) and sum(A·B). Results are presented on a valid/ready output port for the downstream normaliser and divider. It sits between the HV memory reader and the similarity ranking logic.

## Interface
- DATA_WIDTH, 16, signed element width.
- LANES, 4, element pairs per beat (power of 2, ≥1).
- ACC_WIDTH, 48, signed accumulator width; must be ≥ 2*DATA_WIDTH+clog2(LANES).
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_first  in  1  beat is the first of a vector.
- in_last  in  1  beat is the last of a vector.
- a_data  in  LANES*DATA_WIDTH  A elements, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- b_data  in  LANES*DATA_WIDTH  B elements, same packing.
- lane_mask  in  LANES  1 = lane contributes; 0 = lane treated as zero.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer takes results.
- AA_out, BB_out, AB_out  out  ACC_WIDTH each  final sums, signed.
- count_out  out  32  number of unmasked elements accumulated.
- overflow  out  1  any accumulator overflowed during this vector.
- framing_err  out  1  sticky; beat dropped for framing violation.

## Operation
- Beat accepted when in_valid & in_ready. in_ready = (state==IDLE | state==ACCUM) & ~reset.
- States: IDLE, ACCUM, DRAIN, HOLD.
- IDLE: an accepted beat with in_first=1 clears accumulators, count and overflow, and enters the pipeline. Next state is DRAIN if in_last, else ACCUM. An accepted beat with in_first=0 is dropped: framing_err is set and the state stays IDLE.
- ACCUM: an accepted beat enters the pipeline; in_last moves to DRAIN. in_first=1 in ACCUM restarts: partial sums are discarded, the beat becomes the new first beat, and framing_err is set.
- DRAIN: lasts exactly 3 cycles, with in_ready=0. Then HOLD.
- HOLD: out_valid=1, outputs stable. On out_ready the state goes to IDLE and out_valid falls on the next edge.
- Stage 1: per-lane products a*a, b*b, a*b (2*DATA_WIDTH signed), zeroed where the mask bit is 0. Stage 2: adder tree across lanes, one register, width 2*DATA_WIDTH+clog2(LANES). Stage 3: sign-extend and add into the accumulators.
- Overflow is detected from the sign of the ACC_WIDTH+1 sum. With SATURATE=1 the result clamps to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1). With SATURATE=0 it wraps. Either way overflow is set sticky for the vector.
- count_out increments by popcount(lane_mask) per accepted beat.
- framing_err clears on the out_valid & out_ready handshake.

## Timing
- Reset values: in_ready=0 while reset is high and 1 on the first cycle after release. out_valid=0; AA/BB/AB_out=0; count_out=0; overflow=0; framing_err=0; state=IDLE; all pipeline valid bits 0.
- Latency: the last beat is accepted at edge E. Its products register at E, lane sums at E+1, accumulators at E+2, outputs register and out_valid rises at E+3.
- Throughput: 1 beat/cycle during ACCUM. in_valid gaps insert bubbles and do not affect results.
- Back-to-back vectors: the first beat of the next vector is accepted no earlier than the cycle after the output handshake.
- Outputs change only on entry to HOLD and on reset.
- Reset mid-operation (any state): pipeline and accumulators are flushed, and no out_valid is produced for the interrupted vector.
- A single-beat vector (in_first & in_last) is legal.

## Test plan
- Single beat, LANES=4, A={1,2,3,4}, B={4,3,2,1}, mask=1111, first&last → out_valid 3 cycles after accept; AA=30, BB=30, AB=20, count=4, overflow=0.
- Two beats with a 2-cycle in_valid gap. Beat 1 as above; beat 2 A={5,6,9,9}, B={-1,2,9,9}, mask=0011 → AA=91, BB=35, AB=27, count=6.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 → outputs stable, in_ready=0, no beat accepted; out_ready=1 → IDLE, next vector accepted.
- Saturation: ACC_WIDTH=34, all lanes a=b=-32768, 2 beats → AA=BB=AB=2^33-1, overflow=1. Same with SATURATE=0 → AA=-2^33, overflow=1.
- Framing: beat with in_first=0 in IDLE → dropped, framing_err=1, no out_valid. Then a valid vector completes and framing_err clears at the handshake.
- Reset asserted during DRAIN → next cycle out_valid=0, outputs 0, in_ready=1 after release. A following vector produces correct sums.
